// File: rtl/pattern_loader.sv
// pattern_loader: serialises host bytes MSB-first into the pattern buffer chain,
// assembles the bits returned on sout into readback bytes, and offers a non-destructive dump.
module pattern_loader #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [buffer_width-1:0] in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    ssel,
    output logic                    sin,
    input  logic                    sout,
    output logic [buffer_width-1:0] rb_byte,
    output logic                    rb_valid,
    output logic                    busy,
    output logic                    done
);
    localparam int BW = $clog2(buffer_width);
    localparam int CW = $clog2(buffer_size + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

    state_t                  state, state_n;
    logic                    mode_r, last_bit, last_byte;
    logic [BW-1:0]           bit_cnt;
    logic [CW-1:0]           byte_cnt;
    logic [buffer_width-1:0] sr, rb_sh;

    always_comb begin
        last_bit  = bit_cnt == BW'(buffer_width - 1);
        last_byte = byte_cnt == CW'(buffer_size - 1);
        in_ready  = state == FETCH;
        ssel      = state == SHIFT;
        // dump feeds sout straight back so the chain rotates onto itself
        sin       = ssel & (mode_r ? sout : sr[buffer_width-1]);
        state_n   = state;
        case (state)
            IDLE:    state_n = start ? (mode ? SHIFT : FETCH) : IDLE;
            FETCH:   state_n = in_valid ? SHIFT : FETCH;
            SHIFT:   state_n = !last_bit ? SHIFT : last_byte ? IDLE : mode_r ? SHIFT : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            rb_sh    <= '0;
            rb_byte  <= '0;
            rb_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            rb_valid <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE && start) begin
                mode_r   <= mode;
                busy     <= 1'b1;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (state == FETCH && in_valid)
                sr <= in_byte;
            // sout is sampled before the buffer shifts, so the first bit is the byte MSB
            if (ssel) begin
                sr      <= sr << 1;
                rb_sh   <= {rb_sh[buffer_width-2:0], sout};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) begin
                    rb_byte  <= {rb_sh[buffer_width-2:0], sout};
                    rb_valid <= 1'b1;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (last_byte) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: drives pattern_loader against a shift-chain buffer stub and checks
// readback order, final buffer contents, shift counts and latency against an array model.
module tb_pattern_loader;
    localparam int N  = 22;
    localparam int W  = 8;
    localparam int NB = N * W;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0;
    logic [W-1:0] in_byte = '0, rb_byte;
    logic         in_ready, ssel, sin, sout, rb_valid, busy, done;

    always #5 clk = ~clk;

    pattern_loader #(.buffer_size(N), .buffer_width(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .ssel(ssel), .sin(sin), .sout(sout),
        .rb_byte(rb_byte), .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    // buffer stub: entry i occupies chain[i*W +: W]; sout is the MSB of entry N-1
    logic [NB-1:0] chain = '0, pl_data = '0;
    logic          pl_en = 1'b0;
    assign sout = chain[NB-1];
    always @(posedge clk)
        if (pl_en) chain <= pl_data;
        else if (ssel) chain <= {chain[NB-2:0], sin};

    int           cyc = 0, ssel_cnt = 0, done_cnt = 0, overlap = 0, done_norb = 0, busy_t = 0, done_t = 0;
    logic         busy_q = 1'b0;
    logic [W-1:0] rb_q [$];
    int           rb_t [$];
    always @(negedge clk) begin
        cyc++;
        if (ssel) ssel_cnt++;
        if (ssel && in_ready) overlap++;
        if (rb_valid) begin
            rb_q.push_back(rb_byte);
            rb_t.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_t = cyc;
            if (!rb_valid) done_norb++;
        end
        if (busy && !busy_q) busy_t = cyc;
        busy_q = busy;
    end

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] ld [N];
    int           op_ssel, op_lat, op_done, op_rb0;

    function automatic logic [W-1:0] entry(input int i);
        return chain[i*W +: W];
    endfunction

    function automatic logic [W-1:0] rb_at(input int k);
        return (rb_q.size() > op_rb0 + k) ? rb_q[op_rb0 + k] : 'x;
    endfunction

    task automatic preload(input logic [W-1:0] v [N]);
        for (int i = 0; i < N; i++) pl_data[i*W +: W] = v[i];
        @(negedge clk);
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // runs one operation; gap = FETCH cycles with in_valid low before each byte is offered
    task automatic do_op(input bit m, input int gap, input int abort_at, input int poke_at, output bit aborted);
        int idx = 0, wt = 0, s0, d0;
        bit offered = 0, fin = 0;
        s0 = ssel_cnt;
        d0 = done_cnt;
        op_rb0 = rb_q.size();
        aborted = 0;
        @(negedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(negedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        for (int c = 0; c < 3000; c++) begin
            if (offered) begin
                idx++;
                wt = 0;
            end
            if (!m && in_ready) begin
                in_valid = wt >= gap;
                if (wt < gap) wt++;
            end else
                in_valid = (gap == 0) && idx < N;
            in_byte = ld[idx < N ? idx : 0];
            offered = in_valid && in_ready;
            start   = c == poke_at;
            if (abort_at >= 0 && ssel_cnt - s0 == abort_at) begin
                reset   = 1'b1;
                aborted = 1;
                break;
            end
            if (done_cnt != d0) begin
                fin = 1;
                break;
            end
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        op_ssel  = ssel_cnt - s0;
        op_lat   = done_t - busy_t;
        op_done  = done_cnt - d0;
        if (!aborted && !fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_timeout: no done within 3000 cycles (mode %0d)", m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++;
        if ({ssel, sin, in_ready, rb_valid, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 000000", {ssel, sin, in_ready, rb_valid, busy, done});
        end
        n_chk++;
        if (rb_byte !== '0) begin
            n_fail++;
            $display("FAIL reset_rb_byte got %h want 00", rb_byte);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++;
        if ({busy, ssel} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_start_ignored busy/ssel got %b want 00", {busy, ssel});
        end
    endtask

    task automatic test_load_seq();
        logic [W-1:0] old [N];
        bit ab;
        for (int i = 0; i < N; i++) begin
            ld[i]  = W'(i);
            old[i] = entry(i);
        end
        do_op(1'b0, 0, -1, -1, ab);
        n_chk++;
        if (op_done != 1) begin n_fail++; $display("FAIL load_seq_done got %0d want 1", op_done); end
        n_chk++;
        if (op_ssel != NB) begin n_fail++; $display("FAIL load_seq_ssel got %0d want %0d", op_ssel, NB); end
        n_chk++;
        if (op_lat != 198) begin n_fail++; $display("FAIL load_seq_latency got %0d want 198", op_lat); end
        n_chk++;
        if (done_norb != 0) begin n_fail++; $display("FAIL load_seq_done_rb got %0d lone done want 0", done_norb); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (rb_at(k) !== old[N-1-k]) begin n_fail++; $display("FAIL load_seq_rb[%0d] got %h want %h", k, rb_at(k), old[N-1-k]); end
            n_chk++;
            if (entry(N-1-k) !== ld[k]) begin n_fail++; $display("FAIL load_seq_entry[%0d] got %h want %h", N-1-k, entry(N-1-k), ld[k]); end
        end
    endtask

    task automatic test_dump();
        logic [W-1:0] v [N];
        bit ab;
        for (int i = 0; i < N; i++) v[i] = W'(8'hA0 + i);
        preload(v);
        do_op(1'b1, 0, -1, -1, ab);
        n_chk++;
        if (op_done != 1) begin n_fail++; $display("FAIL dump_done got %0d want 1", op_done); end
        n_chk++;
        if (op_ssel != NB) begin n_fail++; $display("FAIL dump_ssel got %0d want %0d", op_ssel, NB); end
        n_chk++;
        if (op_lat != NB) begin n_fail++; $display("FAIL dump_latency got %0d want %0d", op_lat, NB); end
        n_chk++;
        if (rb_q.size() - op_rb0 != N) begin n_fail++; $display("FAIL dump_rb_count got %0d want %0d", rb_q.size() - op_rb0, N); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (rb_at(k) !== v[N-1-k]) begin n_fail++; $display("FAIL dump_rb[%0d] got %h want %h", k, rb_at(k), v[N-1-k]); end
            n_chk++;
            if (entry(k) !== v[k]) begin n_fail++; $display("FAIL dump_entry[%0d] got %h want %h", k, entry(k), v[k]); end
            if (k > 0 && rb_q.size() > op_rb0 + k) begin
                n_chk++;
                if (rb_t[op_rb0+k] - rb_t[op_rb0+k-1] != W) begin
                    n_fail++;
                    $display("FAIL dump_spacing[%0d] got %0d want %0d", k, rb_t[op_rb0+k] - rb_t[op_rb0+k-1], W);
                end
            end
        end
    endtask

    task automatic test_load_overwrite();
        logic [W-1:0] v [N];
        bit ab;
        for (int i = 0; i < N; i++) begin
            v[i]  = W'(8'hA0 + i);
            ld[i] = 8'h5A;
        end
        preload(v);
        do_op(1'b0, 0, -1, -1, ab);
        n_chk++;
        if (op_done != 1) begin n_fail++; $display("FAIL overwrite_done got %0d want 1", op_done); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (rb_at(k) !== v[N-1-k]) begin n_fail++; $display("FAIL overwrite_rb[%0d] got %h want %h", k, rb_at(k), v[N-1-k]); end
            n_chk++;
            if (entry(k) !== 8'h5A) begin n_fail++; $display("FAIL overwrite_entry[%0d] got %h want 5a", k, entry(k)); end
        end
    endtask

    task automatic test_load_gaps();
        bit ab;
        int ov0 = overlap;
        for (int i = 0; i < N; i++) ld[i] = W'($urandom);
        do_op(1'b0, 2, -1, -1, ab);
        n_chk++;
        if (op_lat != 198 + 2 * N) begin n_fail++; $display("FAIL gaps_latency got %0d want %0d", op_lat, 198 + 2 * N); end
        n_chk++;
        if (op_ssel != NB) begin n_fail++; $display("FAIL gaps_ssel got %0d want %0d", op_ssel, NB); end
        n_chk++;
        if (overlap != ov0) begin n_fail++; $display("FAIL gaps_ssel_in_fetch got %0d cycles want 0", overlap - ov0); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (entry(N-1-k) !== ld[k]) begin n_fail++; $display("FAIL gaps_entry[%0d] got %h want %h", N-1-k, entry(N-1-k), ld[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] old [N];
        bit ab;
        int d0 = done_cnt;
        for (int i = 0; i < N; i++) ld[i] = W'($urandom);
        do_op(1'b0, 0, 5 * W + 4, -1, ab);
        n_chk++;
        if (!ab) begin n_fail++; $display("FAIL reset_mid_reached got 0 want 1"); end
        @(negedge clk); #1;
        n_chk++;
        if ({ssel, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_outputs ssel/busy/done got %b want 000", {ssel, busy, done}); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_chk++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d want 0", done_cnt - d0); end
        for (int i = 0; i < N; i++) begin
            old[i] = entry(i);
            ld[i]  = W'($urandom);
        end
        do_op(1'b0, 0, -1, -1, ab);
        n_chk++;
        if (op_lat != 198) begin n_fail++; $display("FAIL reset_mid_reload_latency got %0d want 198", op_lat); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (rb_at(k) !== old[N-1-k]) begin n_fail++; $display("FAIL reset_mid_rb[%0d] got %h want %h", k, rb_at(k), old[N-1-k]); end
            n_chk++;
            if (entry(N-1-k) !== ld[k]) begin n_fail++; $display("FAIL reset_mid_entry[%0d] got %h want %h", N-1-k, entry(N-1-k), ld[k]); end
        end
    endtask

    task automatic test_start_during_dump();
        logic [W-1:0] v [N];
        bit ab;
        int d0 = done_cnt;
        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        preload(v);
        do_op(1'b1, 0, -1, 50, ab);
        repeat (20) @(negedge clk);
        #1;
        n_chk++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL poke_done_count got %0d want 1", done_cnt - d0); end
        n_chk++;
        if (rb_q.size() - op_rb0 != N) begin n_fail++; $display("FAIL poke_rb_count got %0d want %0d", rb_q.size() - op_rb0, N); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL poke_busy_after got %b want 0", busy); end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (entry(k) !== v[k]) begin n_fail++; $display("FAIL poke_entry[%0d] got %h want %h", k, entry(k), v[k]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v [N];
        bit ab, m;
        int gap, lat;
        for (int it = 0; it < 4; it++) begin
            m   = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                v[i]  = W'($urandom);
                ld[i] = W'($urandom);
            end
            preload(v);
            do_op(m, gap, -1, -1, ab);
            lat = m ? NB : 198 + gap * N;
            n_chk++;
            if (op_lat != lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", it, op_lat, lat); end
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if (rb_at(k) !== v[N-1-k]) begin n_fail++; $display("FAIL rand%0d_rb[%0d] got %h want %h", it, k, rb_at(k), v[N-1-k]); end
                n_chk++;
                if (entry(N-1-k) !== (m ? v[N-1-k] : ld[k])) begin
                    n_fail++;
                    $display("FAIL rand%0d_entry[%0d] got %h want %h", it, N-1-k, entry(N-1-k), m ? v[N-1-k] : ld[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_seq();
        test_dump();
        test_load_overwrite();
        test_load_gaps();
        test_reset_mid();
        test_start_during_dump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Serial load/readback controller that sits directly upstream of the pattern buffer.
- Accepts pattern bytes from the host/config side over a valid/ready handshake and serialises them MSB-first into the buffer's shift chain via ssel/sin.
- Assembles the bits returned on sout into readback bytes.
- Also provides a non-destructive dump mode that rotates the chain (sin = sout) so the host can read the buffer without altering it.

Parameters:
- buffer_size, 22, number of pattern entries in the downstream buffer
- buffer_width, 8, bits per entry

Ports:
- clk  input  1  system clock, shared with the pattern buffer
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin an operation; ignored while busy
- mode  input  1  sampled with start: 0 = LOAD, 1 = DUMP
- in_byte  input  buffer_width  load data
- in_valid  input  1  load data valid
- in_ready  output  1  loader accepts in_byte this cycle
- ssel  output  1  shift enable to the pattern buffer
- sin  output  1  serial data to the pattern buffer
- sout  input  1  serial data from the pattern buffer (MSB of the last entry)
- rb_byte  output  buffer_width  assembled readback byte
- rb_valid  output  1  one-cycle pulse; rb_byte is valid
- busy  output  1  operation in progress; the PAT core must not issue field_write while high
- done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Reset: state IDLE; ssel, sin, in_ready, rb_valid, busy and done all 0; rb_byte 0; counters 0.
- A reset mid-operation drops ssel the cycle after the reset edge. Buffer contents stay partially shifted. No done pulse is generated.
- States: IDLE, FETCH, SHIFT.
- IDLE: start & ~mode -> FETCH. start & mode -> SHIFT, with the byte counter cleared. busy = 1 from the following cycle.
- FETCH (LOAD only):
  - in_ready = 1.
  - On in_valid & in_ready: latch in_byte into the shift register, move to SHIFT, and set ssel = 1 and sin = in_byte[buffer_width-1] for the next cycle.
  - in_valid low: remain in FETCH indefinitely.
- SHIFT:
  - ssel = 1 for exactly buffer_width consecutive cycles per byte.
  - LOAD: sin is a flop output presenting the shift register MSB each cycle (MSB first).
  - DUMP: sin = sout combinationally, so the chain rotates.
  - On every edge with ssel = 1, sout is captured into the readback register at bit 0, shifting left. This is the pre-shift bit, so the first captured bit becomes the byte MSB.
  - After the buffer_width-th shift, rb_byte is updated and rb_valid pulses in the next cycle. There is no backpressure on rb_valid.
  - Byte counter increments after each byte's final shift.
  - Counter < buffer_size: LOAD -> FETCH; DUMP stays in SHIFT with ssel held high, no gap.
  - Counter = buffer_size: -> IDLE, done pulse coincident with the final rb_valid, busy drops in the same cycle.
- Ordering:
  - The first byte loaded lands in entry buffer_size-1 and the last byte in entry 0.
  - Readback bytes emerge in the same order, entry buffer_size-1 first, with the old contents before LOAD overwrites them.
- Throughput:
  - LOAD: buffer_width+1 cycles per byte with in_valid held high, i.e. 198 cycles from busy rising to done at the defaults.
  - DUMP: buffer_width × buffer_size consecutive ssel cycles, i.e. 176 at the defaults.
- After DUMP, buffer contents are bit-identical to those before it.
- start while busy: ignored, with no effect on the running operation.
- start coincident with reset: reset wins.
- in_valid in IDLE or SHIFT: not accepted (in_ready = 0).
- Counter widths are $clog2(buffer_width) and $clog2(buffer_size+1). Counter wrap is impossible by construction.

Test Plan:
- Reset, then LOAD 22 bytes 0x00..0x15 with in_valid held high -> buffer entry 21 = 0x00 and entry 0 = 0x15. Exactly 176 ssel cycles. done at 198 cycles after busy rises.
- Preload buffer with entry i = 0xA0+i, then DUMP -> 22 rb_valid pulses, rb_byte = 0xB5, 0xB4 … 0xA0 at 8-cycle spacing. Buffer unchanged afterwards.
- LOAD over preloaded 0xA0+i with new data 0x5A -> rb_byte sequence 0xB5…0xA0 and all entries end at 0x5A.
- LOAD with in_valid toggled (2 cycles low between bytes) -> ssel never asserted in FETCH, no bits lost. Final contents are correct and done is delayed by 44 cycles.
- Assert reset during byte 5, bit 3 -> ssel = 0 next cycle, busy = 0, no done. A new LOAD completes correctly.
- start pulsed during an active DUMP -> ignored; exactly 22 rb_valid pulses and one done.
